// File: rtl/axi_read_arbiter_pkg.sv
// Shared types for the AXI read-path arbiter: FSM states, master indices
// and the default watchdog depth.
package axi_read_arbiter_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      ADDR = 2'd1,
      DATA = 2'd2
   } arb_state_t;

   typedef enum logic {
      M0 = 1'b0,
      M1 = 1'b1
   } master_t;

   localparam int DEFAULT_TIMEOUT = 1024;

endpackage

// File: rtl/axi_read_arbiter_if.sv
// Read-path handshake and grant signals between the two masters, the decoded
// slave and the arbiter.
interface axi_read_arbiter_if;

   logic arvalid_m0;
   logic arvalid_m1;
   logic arready_sel;
   logic rvalid_sel;
   logic rready_sel;
   logic rlast_sel;
   logic grant_m0;
   logic grant_m1;
   logic busy;
   logic timeout_err;

   // Arbiter side: observes the handshakes, drives grants and status
   modport slave (
      input  arvalid_m0, arvalid_m1, arready_sel, rvalid_sel, rready_sel, rlast_sel,
      output grant_m0, grant_m1, busy, timeout_err
   );

   // Interconnect side: supplies the handshakes, consumes grants and status
   modport master (
      output arvalid_m0, arvalid_m1, arready_sel, rvalid_sel, rready_sel, rlast_sel,
      input  grant_m0, grant_m1, busy, timeout_err
   );

endinterface

// File: rtl/axi_read_arbiter_rr_pick2.sv
// Combinational two-way round-robin picker: on a tie the master that did not
// own the previous transaction wins; result is one-hot or zero.
module rr_pick2
   import axi_read_arbiter_pkg::*;
(
   input  logic       req0,
   input  logic       req1,
   input  master_t    rr_last,
   output logic [1:0] pick
);

   always_comb begin
      pick = {req1, req0};
      if (req0 && req1) begin
         pick = (rr_last == M1) ? 2'b01 : 2'b10;
      end
   end

endmodule

// File: rtl/axi_read_arbiter.sv
// Grants the shared AXI read path to one master per transaction, holding the
// grant from address handshake to last data beat, with a watchdog release.
module axi_read_arbiter
   import axi_read_arbiter_pkg::*;
#(
   parameter  int TIMEOUT = DEFAULT_TIMEOUT,
   localparam int CNT_W   = $clog2(TIMEOUT + 1)
) (
   input  logic               ACLK,
   input  logic               ARESETn,
   axi_read_arbiter_if.slave  bus
);

   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

   arb_state_t       state;
   master_t          rr_last;
   logic [CNT_W-1:0] cnt;
   logic             grant0_q;
   logic             grant1_q;
   logic             busy_q;
   logic             timeout_q;

   logic [1:0] pick;
   logic       ar_sel;
   logic       ar_done;
   logic       r_done;
   logic       expired;
   master_t    owner;

   rr_pick2 u_pick (
      .req0    (bus.arvalid_m0),
      .req1    (bus.arvalid_m1),
      .rr_last (rr_last),
      .pick    (pick)
   );

   assign ar_sel  = grant1_q ? bus.arvalid_m1 : bus.arvalid_m0;
   assign ar_done = ar_sel & bus.arready_sel;
   assign r_done  = bus.rvalid_sel & bus.rready_sel & bus.rlast_sel;
   assign expired = (cnt == CNT_LAST);
   assign owner   = grant1_q ? M1 : M0;

   // Single registered FSM; the counter saturates at the expiry value so a
   // stuck transaction is released exactly once, and completion beats expiry.
   always_ff @(posedge ACLK or negedge ARESETn) begin
      if (!ARESETn) begin
         state     <= IDLE;
         rr_last   <= M1;
         cnt       <= '0;
         grant0_q  <= 1'b0;
         grant1_q  <= 1'b0;
         busy_q    <= 1'b0;
         timeout_q <= 1'b0;
      end else begin
         timeout_q <= 1'b0;
         case (state)
            IDLE: begin
               if (|pick) begin
                  state    <= ADDR;
                  grant0_q <= pick[0];
                  grant1_q <= pick[1];
                  busy_q   <= 1'b1;
                  cnt      <= '0;
               end
            end
            ADDR, DATA: begin
               if (cnt != CNT_LAST) begin
                  cnt <= cnt + 1'b1;
               end
               if (state == DATA && r_done) begin
                  state    <= IDLE;
                  grant0_q <= 1'b0;
                  grant1_q <= 1'b0;
                  busy_q   <= 1'b0;
                  rr_last  <= owner;
                  cnt      <= '0;
               end else if (expired) begin
                  state     <= IDLE;
                  grant0_q  <= 1'b0;
                  grant1_q  <= 1'b0;
                  busy_q    <= 1'b0;
                  timeout_q <= 1'b1;
                  rr_last   <= owner;
                  cnt       <= '0;
               end else if (state == ADDR && ar_done) begin
                  state <= DATA;
               end
            end
            default: begin
               state    <= IDLE;
               grant0_q <= 1'b0;
               grant1_q <= 1'b0;
               busy_q   <= 1'b0;
               cnt      <= '0;
            end
         endcase
      end
   end

   assign bus.grant_m0    = grant0_q;
   assign bus.grant_m1    = grant1_q;
   assign bus.busy        = busy_q;
   assign bus.timeout_err = timeout_q;

endmodule

// File: tb/tb_axi_read_arbiter.sv
// Scoreboard bench for axi_read_arbiter: stimulus queues the expected output
// changes with their cycle numbers, monitors pop and compare on every change.
module tb_axi_read_arbiter;

   typedef struct {
      logic [3:0] vec;
      int         at;
      string      name;
   } exp_t;

   logic ACLK;
   logic ARESETn;
   int   cyc;
   int   checks;
   int   errors;

   exp_t q_a[$];
   exp_t q_b[$];

   logic [3:0] prev_a;
   logic [3:0] prev_b;

   axi_read_arbiter_if ifa ();
   axi_read_arbiter_if ifb ();

   axi_read_arbiter dut_a (
      .ACLK    (ACLK),
      .ARESETn (ARESETn),
      .bus     (ifa.slave)
   );

   axi_read_arbiter #(.TIMEOUT(8)) dut_b (
      .ACLK    (ACLK),
      .ARESETn (ARESETn),
      .bus     (ifb.slave)
   );

   initial begin
      ACLK = 1'b0;
      forever #5 ACLK = ~ACLK;
   end

   always @(posedge ACLK) cyc <= cyc + 1;

   // Output vector is {timeout_err, busy, grant_m1, grant_m0}
   task automatic check_vec(input int which, input logic [3:0] got);
      exp_t e;
      checks++;
      if ((which == 0 && q_a.size() == 0) || (which == 1 && q_b.size() == 0)) begin
         errors++;
         $display("[TB] FAIL unexpected_change dut=%0d got=%b at cycle %0d", which, got, cyc);
      end else begin
         if (which == 0) e = q_a.pop_front();
         else            e = q_b.pop_front();
         if (got !== e.vec || cyc != e.at) begin
            errors++;
            $display("[TB] FAIL %s dut=%0d got=%b@%0d expected=%b@%0d",
                     e.name, which, got, cyc, e.vec, e.at);
         end
      end
   endtask

   always @(negedge ACLK) begin
      logic [3:0] va;
      logic [3:0] vb;
      va = {ifa.timeout_err, ifa.busy, ifa.grant_m1, ifa.grant_m0};
      vb = {ifb.timeout_err, ifb.busy, ifb.grant_m1, ifb.grant_m0};
      if (va !== prev_a) begin
         check_vec(0, va);
         prev_a = va;
      end
      if (vb !== prev_b) begin
         check_vec(1, vb);
         prev_b = vb;
      end
   end

   task automatic push_exp(input int which, input logic [3:0] vec, input int at, input string name);
      exp_t e;
      e.vec  = vec;
      e.at   = at;
      e.name = name;
      if (which == 0) q_a.push_back(e);
      else            q_b.push_back(e);
   endtask

   task automatic step(input int n);
      repeat (n) @(negedge ACLK);
   endtask

   task automatic applyStimulus(input int which, input logic a0, input logic a1, input logic ar,
                                input logic rv, input logic rr, input logic rl);
      if (which == 0) begin
         ifa.arvalid_m0 = a0; ifa.arvalid_m1 = a1; ifa.arready_sel = ar;
         ifa.rvalid_sel = rv; ifa.rready_sel = rr; ifa.rlast_sel = rl;
      end else begin
         ifb.arvalid_m0 = a0; ifb.arvalid_m1 = a1; ifb.arready_sel = ar;
         ifb.rvalid_sel = rv; ifb.rready_sel = rr; ifb.rlast_sel = rl;
      end
   endtask

   task automatic checkOutput(input string name, input logic [3:0] got, input logic [3:0] want);
      checks++;
      if (got !== want) begin
         errors++;
         $display("[TB] FAIL %s got=%b expected=%b", name, got, want);
      end
   endtask

   // One-beat transaction from IDLE for a single requesting master
   task automatic single_txn(input int which, input int m, input string name);
      logic [3:0] gvec;
      gvec = (m == 0) ? 4'b0101 : 4'b0110;
      applyStimulus(which, m == 0, m == 1, 1'b0, 1'b0, 1'b0, 1'b0);
      push_exp(which, gvec, cyc + 1, {name, "_grant"});
      step(1);
      applyStimulus(which, m == 0, m == 1, 1'b1, 1'b0, 1'b0, 1'b0);
      step(1);
      applyStimulus(which, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
      push_exp(which, 4'b0000, cyc + 1, {name, "_release"});
      step(1);
      applyStimulus(which, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
   endtask

   initial begin
      cyc    = 0;
      checks = 0;
      errors = 0;
      prev_a = 4'b0000;
      prev_b = 4'b0000;
      applyStimulus(0, 0, 0, 0, 0, 0, 0);
      applyStimulus(1, 0, 0, 0, 0, 0, 0);
      ARESETn = 1'b1;
      #1 ARESETn = 1'b0;
      step(2);
      checkOutput("reset_a", {ifa.timeout_err, ifa.busy, ifa.grant_m1, ifa.grant_m0}, 4'b0000);
      checkOutput("reset_b", {ifb.timeout_err, ifb.busy, ifb.grant_m1, ifb.grant_m0}, 4'b0000);
      ARESETn = 1'b1;
      step(2);

      // Single master 0 request, address accepted on the third cycle
      applyStimulus(0, 1, 0, 0, 0, 0, 0);
      push_exp(0, 4'b0101, cyc + 1, "s1_grant_m0");
      step(3);
      applyStimulus(0, 1, 0, 1, 0, 0, 0);
      step(1);
      applyStimulus(0, 0, 0, 0, 1, 1, 1);
      push_exp(0, 4'b0000, cyc + 1, "s1_release");
      step(1);
      applyStimulus(0, 0, 0, 0, 0, 0, 0);
      step(2);

      ARESETn = 1'b0;
      step(1);
      ARESETn = 1'b1;
      step(1);

      // Both masters requesting, 4-beat bursts: M0, M1, M0, M1 with a bubble
      for (int k = 0; k < 4; k++) begin
         applyStimulus(0, 1, 1, 0, 0, 0, 0);
         push_exp(0, (k % 2 == 0) ? 4'b0101 : 4'b0110, cyc + 1, $sformatf("s2_grant_%0d", k));
         step(1);
         applyStimulus(0, 1, 1, 1, 0, 0, 0);
         step(1);
         applyStimulus(0, 1, 1, 0, 1, 1, 0);
         step(3);
         applyStimulus(0, 1, 1, 0, 1, 1, 1);
         push_exp(0, 4'b0000, cyc + 1, $sformatf("s2_release_%0d", k));
         step(1);
      end
      applyStimulus(0, 0, 0, 0, 0, 0, 0);
      step(2);

      // Master 1 with five stalled beats, then three beats ending in RLAST
      applyStimulus(0, 0, 1, 0, 0, 0, 0);
      push_exp(0, 4'b0110, cyc + 1, "s3_grant_m1");
      step(1);
      applyStimulus(0, 0, 1, 1, 0, 0, 0);
      step(1);
      applyStimulus(0, 0, 0, 0, 1, 0, 0);
      step(5);
      applyStimulus(0, 0, 0, 0, 1, 1, 0);
      step(2);
      applyStimulus(0, 0, 0, 0, 1, 1, 1);
      push_exp(0, 4'b0000, cyc + 1, "s3_release");
      step(1);
      applyStimulus(0, 0, 0, 0, 0, 0, 0);
      step(2);

      // TIMEOUT=8: address never accepted, watchdog fires 8 cycles after grant
      applyStimulus(1, 1, 0, 0, 0, 0, 0);
      push_exp(1, 4'b0101, cyc + 1, "s4_grant_m0");
      step(8);
      applyStimulus(1, 1, 1, 0, 0, 0, 0);
      push_exp(1, 4'b1000, cyc + 1, "s4_timeout_pulse");
      push_exp(1, 4'b0110, cyc + 2, "s4_tie_to_m1");
      step(2);
      applyStimulus(1, 1, 1, 1, 0, 0, 0);
      step(1);
      applyStimulus(1, 0, 0, 0, 1, 1, 1);
      push_exp(1, 4'b0000, cyc + 1, "s4_m1_release");
      step(1);
      applyStimulus(1, 0, 0, 0, 0, 0, 0);
      step(2);

      // TIMEOUT=8: last beat lands on the expiry cycle, so a normal release
      applyStimulus(1, 1, 0, 0, 0, 0, 0);
      push_exp(1, 4'b0101, cyc + 1, "s5_grant_m0");
      step(1);
      applyStimulus(1, 1, 0, 1, 0, 0, 0);
      step(1);
      applyStimulus(1, 0, 0, 0, 1, 0, 0);
      step(6);
      applyStimulus(1, 0, 0, 0, 1, 1, 1);
      push_exp(1, 4'b0000, cyc + 1, "s5_release_no_err");
      step(1);
      applyStimulus(1, 0, 0, 0, 0, 0, 0);
      step(2);

      // Leave rr_last at M0, then reset in the middle of an M1 data phase
      single_txn(0, 0, "s6_m0");
      step(1);
      applyStimulus(0, 0, 1, 0, 0, 0, 0);
      push_exp(0, 4'b0110, cyc + 1, "s6_grant_m1");
      step(1);
      applyStimulus(0, 0, 1, 1, 0, 0, 0);
      step(1);
      applyStimulus(0, 0, 0, 0, 1, 1, 0);
      @(posedge ACLK);
      #2;
      push_exp(0, 4'b0000, cyc, "s6_async_reset");
      ARESETn = 1'b0;
      #1;
      checkOutput("s6_reset_immediate", {ifa.timeout_err, ifa.busy, ifa.grant_m1, ifa.grant_m0}, 4'b0000);
      step(1);
      applyStimulus(0, 0, 0, 0, 0, 0, 0);
      ARESETn = 1'b1;
      step(1);
      applyStimulus(0, 1, 1, 0, 0, 0, 0);
      push_exp(0, 4'b0101, cyc + 1, "s6_tie_to_m0");
      step(1);
      applyStimulus(0, 1, 1, 1, 0, 0, 0);
      step(1);
      applyStimulus(0, 0, 0, 0, 1, 1, 1);
      push_exp(0, 4'b0000, cyc + 1, "s6_release");
      step(1);
      applyStimulus(0, 0, 0, 0, 0, 0, 0);
      step(4);

      while (q_a.size() > 0) begin
         exp_t e;
         e = q_a.pop_front();
         checks++;
         errors++;
         $display("[TB] FAIL %s dut=0 never seen, expected=%b@%0d", e.name, e.vec, e.at);
      end
      while (q_b.size() > 0) begin
         exp_t e;
         e = q_b.pop_front();
         checks++;
         errors++;
         $display("[TB] FAIL %s dut=1 never seen, expected=%b@%0d", e.name, e.vec, e.at);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
